// File: rtl/datapath_mc_if.sv
// Controller-to-datapath bus for datapath_mc: operand/immediate inputs, load/select/op
// controls, the multiply handshake and the result/status outputs.
interface datapath_mc_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int PC_WIDTH   = 8
);
  localparam int REG_AW = $clog2(NUM_REGS);

  logic [DATA_WIDTH-1:0] mdata;
  logic [DATA_WIDTH-1:0] sximm8;
  logic [DATA_WIDTH-1:0] sximm5;
  logic [PC_WIDTH-1:0]   PC;
  logic [REG_AW-1:0]     writenum;
  logic [REG_AW-1:0]     readnum;
  logic                  write;
  logic                  loada;
  logic                  loadb;
  logic                  loadc;
  logic                  loads;
  logic                  asel;
  logic                  bsel;
  logic [1:0]            vsel;
  logic [1:0]            shift;
  logic [2:0]            ALUop;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] datapath_out;
  logic                  Z_out;
  logic                  N_out;
  logic                  V_out;
  logic                  C_out;

  modport master (
    output mdata, sximm8, sximm5, PC, writenum, readnum,
    output write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop, start,
    input  busy, done, datapath_out, Z_out, N_out, V_out, C_out
  );

  modport slave (
    input  mdata, sximm8, sximm5, PC, writenum, readnum,
    input  write, loada, loadb, loadc, loads, asel, bsel, vsel, shift, ALUop, start,
    output busy, done, datapath_out, Z_out, N_out, V_out, C_out
  );
endinterface

// File: rtl/datapath_mc.sv
// Multi-cycle RISC datapath: register file, A/B/C registers, 2-bit shifter, 8-op ALU
// with carry flag, and an iterative shift-add multiplier behind a start/busy/done handshake.
module datapath_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int PC_WIDTH   = 8
) (
  input logic          clk,
  input logic          reset,
  datapath_mc_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int M  = DATA_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_NOTB = 3'b011,
    OP_OR  = 3'b100, OP_XOR = 3'b101, OP_MUL = 3'b110, OP_RSV  = 3'b111
  } alu_op_t;

  mul_state_t state, state_next;

  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];
  logic [DATA_WIDTH-1:0]   a_reg, b_reg, c_reg;
  logic                    z_reg, n_reg, v_reg, c_flag_reg;
  logic [DATA_WIDTH-1:0]   rd_data, wb_data, b_shift, ain, bin, alu_res;
  logic [DATA_WIDTH:0]     ext;
  logic                    alu_z, alu_n, alu_v, alu_c;
  logic [2*DATA_WIDTH-1:0] mcand, acc;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [CW-1:0]           count;
  logic                    mul_start, busy_i;

  assign rd_data = regs[bus.readnum];

  always_comb begin
    wb_data = c_reg;
    case (bus.vsel)
      2'b00: wb_data = c_reg;
      2'b01: wb_data = DATA_WIDTH'(bus.PC);
      2'b10: wb_data = bus.sximm8;
      2'b11: wb_data = bus.mdata;
      default: wb_data = c_reg;
    endcase
  end

  always_comb begin
    b_shift = b_reg;
    case (bus.shift)
      2'b00: b_shift = b_reg;
      2'b01: b_shift = {b_reg[M-1:0], 1'b0};
      2'b10: b_shift = {1'b0, b_reg[M:1]};
      2'b11: b_shift = {b_reg[M], b_reg[M:1]};
      default: b_shift = b_reg;
    endcase
  end

  assign ain = bus.asel ? '0 : a_reg;
  assign bin = bus.bsel ? bus.sximm5 : b_shift;

  // SUB is A + ~B + 1, so the carry-out is the not-borrow flag directly.
  always_comb begin
    ext     = '0;
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (alu_op_t'(bus.ALUop))
      OP_ADD: begin
        ext     = {1'b0, ain} + {1'b0, bin};
        alu_res = ext[M:0];
        alu_c   = ext[DATA_WIDTH];
        alu_v   = (ain[M] == bin[M]) && (alu_res[M] != ain[M]);
      end
      OP_SUB: begin
        ext     = {1'b0, ain} + {1'b0, ~bin} + (DATA_WIDTH+1)'(1);
        alu_res = ext[M:0];
        alu_c   = ext[DATA_WIDTH];
        alu_v   = (ain[M] != bin[M]) && (alu_res[M] != ain[M]);
      end
      OP_AND:  alu_res = ain & bin;
      OP_NOTB: alu_res = ~bin;
      OP_OR:   alu_res = ain | bin;
      OP_XOR:  alu_res = ain ^ bin;
      default: alu_res = '0;
    endcase
    alu_z = (alu_res == '0);
    alu_n = alu_res[M];
  end

  assign mul_start = (state == IDLE) && bus.start && (bus.ALUop == OP_MUL);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_i     = 1'b0;
    bus.done   = 1'b0;
    case (state)
      IDLE: if (mul_start) state_next = RUN;
      RUN: begin
        busy_i = 1'b1;
        if (count == CW'(1)) state_next = DONE;
      end
      DONE: begin
        busy_i     = 1'b1;
        bus.done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy = busy_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (mul_start) begin
      mcand  <= {{DATA_WIDTH{1'b0}}, ain};
      mplier <= bin;
      acc    <= '0;
      count  <= CW'(DATA_WIDTH);
    end else if (state == RUN) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      z_reg      <= 1'b0;
      n_reg      <= 1'b0;
      v_reg      <= 1'b0;
      c_flag_reg <= 1'b0;
    end else begin
      if (bus.write) regs[bus.writenum] <= wb_data;
      if (bus.loada) a_reg <= rd_data;
      if (bus.loadb) b_reg <= rd_data;
      // The multiplier owns C/status on its final cycle; loadc/loads are locked out while busy.
      if (state == DONE) begin
        c_reg      <= acc[M:0];
        z_reg      <= (acc[M:0] == '0);
        n_reg      <= acc[M];
        v_reg      <= |acc[2*DATA_WIDTH-1:DATA_WIDTH];
        c_flag_reg <= 1'b0;
      end else if (!busy_i) begin
        if (bus.loadc) c_reg <= alu_res;
        if (bus.loads) begin
          z_reg      <= alu_z;
          n_reg      <= alu_n;
          v_reg      <= alu_v;
          c_flag_reg <= alu_c;
        end
      end
    end
  end

  assign bus.datapath_out = c_reg;
  assign bus.Z_out        = z_reg;
  assign bus.N_out        = n_reg;
  assign bus.V_out        = v_reg;
  assign bus.C_out        = c_flag_reg;
endmodule

// File: tb/tb_datapath_mc.sv
// Scoreboard bench for datapath_mc: directed scenarios plus randomized ops, checked
// against an arithmetic reference model by a monitor that watches loadc and done.
module tb_datapath_mc;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  datapath_mc_if #(.DATA_WIDTH(16), .NUM_REGS(8), .PC_WIDTH(8)) bus ();
  datapath_mc #(.DATA_WIDTH(16), .NUM_REGS(8), .PC_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic [15:0] val;
    logic z, n, v, c;
  } exp_t;

  exp_t alu_q[$];
  exp_t mul_q[$];
  int tests = 0;
  int fails = 0;
  logic [15:0] m_regs [8];
  logic [15:0] m_a, m_b, m_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] m_shift(input logic [15:0] b, input logic [1:0] sh);
    case (sh)
      2'd0: return b;
      2'd1: return b << 1;
      2'd2: return b >> 1;
      default: return 16'($signed(b) >>> 1);
    endcase
  endfunction

  function automatic exp_t m_alu(input logic [15:0] x, input logic [15:0] y, input logic [2:0] op);
    exp_t r;
    int sx, sy, s;
    logic [31:0] u;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r = '0;
    case (op)
      3'd0: begin
        r.val = x + y;
        u = 32'(x) + 32'(y);
        r.c = (u > 32'd65535);
        s = sx + sy;
        r.v = (s > 32767) || (s < -32768);
      end
      3'd1: begin
        r.val = x - y;
        r.c = (x >= y);
        s = sx - sy;
        r.v = (s > 32767) || (s < -32768);
      end
      3'd2: r.val = x & y;
      3'd3: r.val = ~y;
      3'd4: r.val = x | y;
      3'd5: r.val = x ^ y;
      default: r.val = 16'h0;
    endcase
    r.z = (r.val == 16'h0);
    r.n = r.val[15];
    return r;
  endfunction

  function automatic exp_t m_mul(input logic [15:0] x, input logic [15:0] y);
    exp_t r;
    logic [31:0] p;
    p = 32'(x) * 32'(y);
    r.val = p[15:0];
    r.z = (p[15:0] == 16'h0);
    r.n = p[15];
    r.v = (p[31:16] != 16'h0);
    r.c = 1'b0;
    return r;
  endfunction

  // Monitor: done marks a multiply result, loadc while idle marks a single-cycle result.
  initial begin
    logic d, l;
    exp_t e;
    forever begin
      @(posedge clk);
      d = bus.done;
      l = bus.loadc && !bus.busy && !reset;
      #1;
      if (d) begin
        if (mul_q.size() == 0) chk("unexpected done", 32'(1), 32'(0));
        else begin
          e = mul_q.pop_front();
          chk("mul result", 32'({bus.datapath_out, bus.Z_out, bus.N_out, bus.V_out, bus.C_out}), 32'(e));
        end
      end else if (l) begin
        if (alu_q.size() == 0) chk("unexpected loadc", 32'(1), 32'(0));
        else begin
          e = alu_q.pop_front();
          chk("alu result", 32'({bus.datapath_out, bus.Z_out, bus.N_out, bus.V_out, bus.C_out}), 32'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic write_src(input int i, input logic [1:0] vs);
    logic [15:0] v;
    case (vs)
      2'd0: v = m_c;
      2'd1: v = 16'(bus.PC);
      2'd2: v = bus.sximm8;
      default: v = bus.mdata;
    endcase
    bus.vsel = vs;
    bus.writenum = 3'(i);
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    m_regs[i] = v;
  endtask

  task automatic write_reg(input int i, input logic [15:0] v);
    bus.sximm8 = v;
    write_src(i, 2'd2);
  endtask

  task automatic load_ab(input int ra, input int rb);
    bus.readnum = 3'(ra);
    bus.loada = 1'b1;
    @(negedge clk);
    bus.loada = 1'b0;
    m_a = m_regs[ra];
    bus.readnum = 3'(rb);
    bus.loadb = 1'b1;
    @(negedge clk);
    bus.loadb = 1'b0;
    m_b = m_regs[rb];
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [1:0] sh, input logic as, input logic bs,
                        input logic [15:0] imm);
    exp_t e;
    bus.ALUop = op; bus.shift = sh; bus.asel = as; bus.bsel = bs; bus.sximm5 = imm;
    bus.loadc = 1'b1; bus.loads = 1'b1;
    e = m_alu(as ? 16'h0 : m_a, bs ? imm : m_shift(m_b, sh), op);
    alu_q.push_back(e);
    m_c = e.val;
    @(negedge clk);
    bus.loadc = 1'b0; bus.loads = 1'b0;
  endtask

  task automatic read_check(input int i);
    bus.readnum = 3'(i);
    bus.loada = 1'b1;
    @(negedge clk);
    bus.loada = 1'b0;
    m_a = m_regs[i];
    alu_op(3'd0, 2'd0, 1'b0, 1'b1, 16'h0);
  endtask

  // mode 0 plain, 1 hold loadc/loads during busy, 2 re-pulse start + write R2, 3 reset mid-run
  task automatic mul_op(input logic [1:0] sh, input logic as, input logic bs, input logic [15:0] imm,
                        input int mode);
    exp_t e;
    int cnt, dcnt;
    bus.ALUop = 3'd6; bus.shift = sh; bus.asel = as; bus.bsel = bs; bus.sximm5 = imm;
    bus.start = 1'b1;
    e = m_mul(as ? 16'h0 : m_a, bs ? imm : m_shift(m_b, sh));
    if (mode != 3) begin
      mul_q.push_back(e);
      m_c = e.val;
    end
    @(negedge clk);
    bus.start = 1'b0;
    if (mode == 1) begin bus.loadc = 1'b1; bus.loads = 1'b1; bus.ALUop = 3'd0; end
    cnt = 0; dcnt = 0;
    while (bus.busy && cnt < 100) begin
      cnt++;
      if (bus.done) begin dcnt++; bus.loadc = 1'b0; bus.loads = 1'b0; end
      if (mode == 2) begin
        bus.start = (cnt == 3);
        if (cnt == 3) begin bus.asel = 1'b1; bus.bsel = 1'b1; bus.sximm5 = 16'h0003; end
        if (cnt == 4) begin
          bus.vsel = 2'd2; bus.sximm8 = 16'h1234; bus.writenum = 3'd2; bus.write = 1'b1;
          m_regs[2] = 16'h1234;
        end else bus.write = 1'b0;
      end
      if (mode == 3 && cnt == 5) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("busy after abort", 32'(bus.busy), 32'(0));
        chk("done after abort", 32'(bus.done), 32'(0));
        chk("C after abort", 32'({bus.datapath_out, bus.Z_out, bus.N_out, bus.V_out, bus.C_out}), 32'(0));
        foreach (m_regs[k]) m_regs[k] = 16'h0;
        m_a = 16'h0; m_b = 16'h0; m_c = 16'h0;
        return;
      end
      @(negedge clk);
    end
    bus.loadc = 1'b0; bus.loads = 1'b0; bus.start = 1'b0; bus.write = 1'b0;
    chk("busy cycles", 32'(cnt), 32'(17));
    chk("done pulses", 32'(dcnt), 32'(1));
  endtask

  initial begin
    logic [15:0] old;
    logic [2:0] op;
    reset = 1'b1;
    bus.mdata = '0; bus.sximm8 = '0; bus.sximm5 = '0; bus.PC = '0;
    bus.writenum = '0; bus.readnum = '0;
    bus.write = 1'b0; bus.loada = 1'b0; bus.loadb = 1'b0; bus.loadc = 1'b0; bus.loads = 1'b0;
    bus.asel = 1'b0; bus.bsel = 1'b0; bus.vsel = '0; bus.shift = '0; bus.ALUop = '0; bus.start = 1'b0;
    foreach (m_regs[k]) m_regs[k] = 16'h0;
    m_a = 16'h0; m_b = 16'h0; m_c = 16'h0;
    repeat (2) @(negedge clk);
    chk("reset out/flags", 32'({bus.datapath_out, bus.Z_out, bus.N_out, bus.V_out, bus.C_out}), 32'(0));
    chk("reset busy/done", 32'({bus.busy, bus.done}), 32'(0));
    reset = 1'b0;

    write_reg(0, 16'd5); write_reg(1, 16'd3);
    load_ab(0, 1);
    alu_op(3'd0, 2'd0, 1'b0, 1'b0, 16'h0);

    write_reg(3, 16'h7FFF); write_reg(4, 16'h0001);
    load_ab(3, 4);
    alu_op(3'd1, 2'd3, 1'b0, 1'b0, 16'h0);
    alu_op(3'd0, 2'd0, 1'b0, 1'b0, 16'h0);

    write_reg(0, 16'd7); write_reg(1, 16'd6);
    load_ab(0, 1);
    mul_op(2'd0, 1'b0, 1'b0, 16'h0, 1);

    write_reg(0, 16'h0100); write_reg(1, 16'h0100);
    load_ab(0, 1);
    mul_op(2'd0, 1'b0, 1'b0, 16'h0, 0);
    load_ab(1, 0);
    mul_op(2'd0, 1'b0, 1'b0, 16'h0, 0);

    write_reg(5, 16'd9); write_reg(6, 16'd11);
    load_ab(5, 6);
    mul_op(2'd0, 1'b0, 1'b0, 16'h0, 2);
    read_check(2);

    old = m_regs[3];
    bus.vsel = 2'd2; bus.sximm8 = 16'hBEEF; bus.writenum = 3'd3; bus.write = 1'b1;
    bus.readnum = 3'd3; bus.loada = 1'b1;
    @(negedge clk);
    bus.write = 1'b0; bus.loada = 1'b0;
    m_a = old; m_regs[3] = 16'hBEEF;
    alu_op(3'd0, 2'd0, 1'b0, 1'b1, 16'h0);
    read_check(3);

    for (int it = 0; it < 40; it++) begin
      bus.PC = 8'($urandom);
      bus.mdata = 16'($urandom);
      bus.sximm8 = 16'($urandom);
      write_src(int'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      load_ab(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      if ($urandom_range(0, 4) == 0)
        mul_op(2'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 0);
      else begin
        op = 3'($urandom_range(0, 6));
        if (op == 3'd6) op = 3'd7;
        alu_op(op, 2'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      end
    end

    write_reg(0, 16'd123); write_reg(1, 16'd45);
    load_ab(0, 1);
    mul_op(2'd0, 1'b0, 1'b0, 16'h0, 3);
    repeat (25) @(negedge clk);
    for (int i = 0; i < 8; i++) read_check(i);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(alu_q.size() + mul_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/datapath_mc.md
# datapath_mc

Parametrised, multi-cycle successor to the RISC machine datapath. It holds an N-entry register file, A/B/C operand and result registers, a 2-bit shifter and an 8-op ALU. The ALU adds a carry flag and an iterative shift-add multiply guarded by a start/busy/done handshake. The block sits under the FSM controller, which drives all load, select and op signals and waits on `done` for multiplies.

## Interface
- `DATA_WIDTH`, 16: width of registers, operands and ALU.
- `NUM_REGS`, 8: register-file depth; must be a power of two; `REG_AW = $clog2(NUM_REGS)`.
- `PC_WIDTH`, 8: width of `PC`; must be ≤ `DATA_WIDTH`.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `mdata`, `sximm8`, `sximm5`  in  DATA_WIDTH: memory data and sign-extended immediates.
- `PC`  in  PC_WIDTH: program counter; zero-extended on write-back.
- `writenum`, `readnum`  in  REG_AW: register-file write and read indices.
- `write`, `loada`, `loadb`, `loadc`, `loads`  in  1 each: register-file, A, B, C and status enables.
- `asel`, `bsel`  in  1 each: Ain = `asel` ? 0 : A; Bin = `bsel` ? `sximm5` : shifted B.
- `vsel`  in  2: write-back source. 00 = C, 01 = {0, `PC`}, 10 = `sximm8`, 11 = `mdata`.
- `shift`  in  2: 00 pass, 01 shift left 1 (LSB 0), 10 logical shift right 1, 11 arithmetic shift right 1.
- `ALUop`  in  3: 000 ADD, 001 SUB (A−B), 010 AND, 011 NOT B, 100 OR, 101 XOR, 110 MUL, 111 reserved (result 0).
- `start`  in  1: launches MUL.
- `busy`  out  1: high while a multiply is in progress.
- `done`  out  1: one-cycle pulse when a multiply completes.
- `datapath_out`  out  DATA_WIDTH: contents of C.
- `Z_out`, `N_out`, `V_out`, `C_out`  out  1 each: status register contents.

## Operation
- Register file:
  - Synchronous write of the `vsel` mux output into `writenum` when `write` is high.
  - Combinational read of `readnum`.
  - A read of the register being written in the same cycle returns the old value.
- A and B capture the read data on `loada` / `loadb`.
- Single-cycle ops (`ALUop` ≠ 110): the ALU is combinational on Ain and Bin.
  - `loadc` captures the result into C.
  - `loads` captures the flags into status.
- Flags:
  - Z = (result == 0).
  - N = result MSB.
  - V = signed overflow for ADD/SUB, else 0.
  - C = carry-out for ADD, not-borrow for SUB, else 0.
  - MUL: Z and N taken from the low product half; V = (upper half ≠ 0) under unsigned interpretation; C = 0.
- MUL state machine has three states.
  - IDLE: `start` with `ALUop` = 110 latches Ain into a multiplicand register and Bin into a multiplier register, clears the 2×DATA_WIDTH accumulator, and moves to RUN. `start` with any other op is ignored.
  - RUN: each cycle, if the multiplier LSB is 1, add the multiplicand into the accumulator. Shift the multiplicand left and the multiplier right. Decrement a counter initialised to DATA_WIDTH. When the counter reaches 0, go to DONE.
  - DONE (one cycle): C ← accumulator[DATA_WIDTH−1:0] and status ← MUL flags, regardless of `loadc` / `loads`. Assert `done`, then return to IDLE.
- While `busy`:
  - `loadc`, `loads` and `start` are ignored.
  - `write`, `loada` and `loadb` operate normally; the operands are already latched.
- `reset` clears, overriding every other input:
  - all registers, A, B, C and status to 0;
  - multiplier state to IDLE;
  - `busy` and `done` to 0.
- Reset mid-multiply aborts the operation: no C or status update and no `done` pulse.

## Timing
- Reset values: `datapath_out` = 0, all flags = 0, `busy` = 0, `done` = 0.
- Single-cycle op: operands are present in A/B before edge k; C and flags are visible after edge k (latency 1).
- MUL, with `start` sampled at edge k:
  - `busy` is high for cycles k+1 … k+DATA_WIDTH+1.
  - C and flags update at edge k+DATA_WIDTH+1.
  - `done` is high for the single cycle after edge k+DATA_WIDTH, coincident with the C load edge.
  - `busy` falls after edge k+DATA_WIDTH+1.
- Back-to-back MUL: `start` is accepted on the edge at which `busy` is already low, earliest edge k+DATA_WIDTH+2.
- Register-file write and A/B capture of the same register at the same edge: A/B get the old value.

## Test plan
- Assert reset, then load R0 = 5 and R1 = 3, and drive ADD, `loadc` and `loads` → `datapath_out` = 8; Z=0, N=0, V=0, C=0 after one edge.
- A = 0x7FFF, B = 1, SUB with `bsel` = 0 and `shift` = 11 (B → 0) → `datapath_out` = 0x7FFF; Z=0, C=1, V=0. Then A = 0x7FFF, B = 1, ADD → 0x8000, N=1, V=1.
- A = 7, B = 6, MUL with `start` pulse (16-bit) → `busy` high for 17 cycles; `done` pulse; `datapath_out` = 42, V=0. `loadc` held high during `busy` does not disturb C.
- A = 0x0100, B = 0x0100, MUL → `datapath_out` = 0, Z=1, V=1.
- `start` re-pulsed mid-multiply with different operands → ignored; result equals the first product. `write` to R2 during `busy` succeeds.
- `reset` asserted 5 cycles into a MUL → `busy` = 0 next cycle; `done` never pulses; C = 0 and all registers read 0.
